// File: rtl/multisim_axi_pkg.sv
// Shared constants and helpers for the multisim AXI pull-side flow-control slice.
package multisim_axi_pkg;

    localparam int unsigned FIFO_DEPTH_DEFAULT      = 4;
    localparam int unsigned MAX_OUTSTANDING_DEFAULT = 8;

    // Width of a counter able to hold the values 0..n inclusive.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/multisim_fifo_fwft.sv
// First-word-fall-through FIFO with extra wrap bit on the pointers.
// Head data is visible on data_o whenever empty_o is low.
module multisim_fifo_fwft #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  full_o,
    input  logic                  pop_i,
    output logic                  empty_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic                  do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    // A pop at full frees the slot the same cycle, so a concurrent push is safe.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Next-state pointer arithmetic, wrapping naturally through the extra bit.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end

    // Pointer registers, flushed on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/multisim_server_axi_pull_ctrl.sv
// Flow-control stage between multisim pull/push servers and an AXI manager port.
// AW/W/AR are buffered in FWFT FIFOs; AW and AR issue is limited by the number
// of outstanding bursts. B and R pass straight through.
// Optional stall statistics: define MULTISIM_SERVER_AXI_PULL_CTRL_STATS_EN.
module multisim_server_axi_pull_ctrl
    import multisim_axi_pkg::*;
#(
    parameter type         axi_aw_t           = logic [31:0],
    parameter type         axi_w_t            = logic [31:0],
    parameter type         axi_b_t            = logic [1:0],
    parameter type         axi_ar_t           = logic [31:0],
    parameter type         axi_r_t            = logic [33:0],
    parameter int unsigned FIFO_DEPTH         = FIFO_DEPTH_DEFAULT,
    parameter int unsigned MAX_WR_OUTSTANDING = MAX_OUTSTANDING_DEFAULT,
    parameter int unsigned MAX_RD_OUTSTANDING = MAX_OUTSTANDING_DEFAULT
) (
    input  logic    clk,
    input  logic    rst,
    input  axi_aw_t s_aw,
    input  logic    s_awvalid,
    output logic    s_awready,
    input  axi_w_t  s_w,
    input  logic    s_wvalid,
    output logic    s_wready,
    input  axi_ar_t s_ar,
    input  logic    s_arvalid,
    output logic    s_arready,
    output axi_b_t  s_b,
    output logic    s_bvalid,
    input  logic    s_bready,
    output axi_r_t  s_r,
    output logic    s_rvalid,
    input  logic    s_rready,
    output axi_aw_t o_axi_m_aw,
    output logic    o_axi_m_awvalid,
    input  logic    i_axi_m_awready,
    output axi_w_t  o_axi_m_w,
    output logic    o_axi_m_wvalid,
    input  logic    i_axi_m_wready,
    output axi_ar_t o_axi_m_ar,
    output logic    o_axi_m_arvalid,
    input  logic    i_axi_m_arready,
    input  axi_b_t  i_axi_m_b,
    input  logic    i_axi_m_bvalid,
    output logic    o_axi_m_bready,
    input  axi_r_t  i_axi_m_r,
    input  logic    i_axi_m_rvalid,
    output logic    o_axi_m_rready,
    input  logic    i_axi_m_rlast,
    output logic [cnt_width(MAX_WR_OUTSTANDING)-1:0] o_wr_outstanding,
    output logic [cnt_width(MAX_RD_OUTSTANDING)-1:0] o_rd_outstanding,
    output logic    o_idle,
    output logic    o_err
`ifdef MULTISIM_SERVER_AXI_PULL_CTRL_STATS_EN
   ,output logic [31:0] o_aw_stall_cycles,
    output logic [31:0] o_ar_stall_cycles
`endif
);

    localparam int unsigned WCW = cnt_width(MAX_WR_OUTSTANDING);
    localparam int unsigned RCW = cnt_width(MAX_RD_OUTSTANDING);
    localparam logic [WCW-1:0] WR_MAX = WCW'(MAX_WR_OUTSTANDING);
    localparam logic [RCW-1:0] RD_MAX = RCW'(MAX_RD_OUTSTANDING);

    logic    aw_full, aw_empty, w_full, w_empty, ar_full, ar_empty;
    axi_aw_t aw_head;
    axi_w_t  w_head;
    axi_ar_t ar_head;
    logic    aw_hs, w_hs, ar_hs, b_hs, r_last_hs;
    logic    aw_gate, ar_gate;
    logic    aw_hold_q, aw_hold_d, ar_hold_q, ar_hold_d;
    logic [WCW-1:0] wr_cnt_q, wr_cnt_d;
    logic [RCW-1:0] rd_cnt_q, rd_cnt_d;
    logic    err_q, err_d;

    multisim_fifo_fwft #(.DATA_WIDTH($bits(axi_aw_t)), .DEPTH(FIFO_DEPTH)) u_aw_fifo (
        .clk(clk), .rst(rst),
        .push_i(s_awvalid && s_awready), .data_i(s_aw), .full_o(aw_full),
        .pop_i(aw_hs), .empty_o(aw_empty), .data_o(aw_head)
    );

    multisim_fifo_fwft #(.DATA_WIDTH($bits(axi_w_t)), .DEPTH(FIFO_DEPTH)) u_w_fifo (
        .clk(clk), .rst(rst),
        .push_i(s_wvalid && s_wready), .data_i(s_w), .full_o(w_full),
        .pop_i(w_hs), .empty_o(w_empty), .data_o(w_head)
    );

    multisim_fifo_fwft #(.DATA_WIDTH($bits(axi_ar_t)), .DEPTH(FIFO_DEPTH)) u_ar_fifo (
        .clk(clk), .rst(rst),
        .push_i(s_arvalid && s_arready), .data_i(s_ar), .full_o(ar_full),
        .pop_i(ar_hs), .empty_o(ar_empty), .data_o(ar_head)
    );

    // Upstream readiness and response pass-through, all forced low during reset.
    always_comb begin
        s_awready      = !rst && !aw_full;
        s_wready       = !rst && !w_full;
        s_arready      = !rst && !ar_full;
        s_b            = rst ? '0 : i_axi_m_b;
        s_bvalid       = !rst && i_axi_m_bvalid;
        o_axi_m_bready = !rst && s_bready;
        s_r            = rst ? '0 : i_axi_m_r;
        s_rvalid       = !rst && i_axi_m_rvalid;
        o_axi_m_rready = !rst && s_rready;
    end

    assign b_hs      = i_axi_m_bvalid && o_axi_m_bready;
    assign r_last_hs = i_axi_m_rvalid && o_axi_m_rready && i_axi_m_rlast;

    // A returning response frees its slot in the same cycle it arrives.
    assign aw_gate = (wr_cnt_q < WR_MAX) || b_hs;
    assign ar_gate = (rd_cnt_q < RD_MAX) || r_last_hs;

    // Downstream request channels; the hold flag keeps an asserted valid up
    // until accepted even if the gate closes meanwhile.
    always_comb begin
        o_axi_m_aw      = aw_head;
        o_axi_m_awvalid = !rst && !aw_empty && (aw_hold_q || aw_gate);
        o_axi_m_w       = w_head;
        o_axi_m_wvalid  = !rst && !w_empty;
        o_axi_m_ar      = ar_head;
        o_axi_m_arvalid = !rst && !ar_empty && (ar_hold_q || ar_gate);
    end

    assign aw_hs = o_axi_m_awvalid && i_axi_m_awready;
    assign w_hs  = o_axi_m_wvalid && i_axi_m_wready;
    assign ar_hs = o_axi_m_arvalid && i_axi_m_arready;

    // Outstanding counters, hold flags and sticky error next-state.
    always_comb begin
        aw_hold_d = o_axi_m_awvalid && !i_axi_m_awready;
        ar_hold_d = o_axi_m_arvalid && !i_axi_m_arready;

        wr_cnt_d = wr_cnt_q;
        if (aw_hs && !b_hs)
            wr_cnt_d = wr_cnt_q + WCW'(1);
        else if (!aw_hs && b_hs && (wr_cnt_q != '0))
            wr_cnt_d = wr_cnt_q - WCW'(1);

        rd_cnt_d = rd_cnt_q;
        if (ar_hs && !r_last_hs)
            rd_cnt_d = rd_cnt_q + RCW'(1);
        else if (!ar_hs && r_last_hs && (rd_cnt_q != '0))
            rd_cnt_d = rd_cnt_q - RCW'(1);

        err_d = err_q || (b_hs && (wr_cnt_q == '0)) || (r_last_hs && (rd_cnt_q == '0));
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_hold_q <= 1'b0;
            ar_hold_q <= 1'b0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            aw_hold_q <= aw_hold_d;
            ar_hold_q <= ar_hold_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            err_q     <= err_d;
        end
    end

    assign o_wr_outstanding = wr_cnt_q;
    assign o_rd_outstanding = rd_cnt_q;
    assign o_err            = err_q;
    assign o_idle           = rst || (aw_empty && w_empty && ar_empty &&
                                      (wr_cnt_q == '0) && (rd_cnt_q == '0));

`ifdef MULTISIM_SERVER_AXI_PULL_CTRL_STATS_EN
    logic        aw_stall, ar_stall;
    logic [31:0] aw_stall_q, ar_stall_q;

    // With no reset asserted, a queued request that is not valid is blocked by the limit.
    assign aw_stall = !rst && !aw_empty && !o_axi_m_awvalid;
    assign ar_stall = !rst && !ar_empty && !o_axi_m_arvalid;

    // Saturating stall-cycle counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_stall_q <= '0;
            ar_stall_q <= '0;
        end else begin
            if (aw_stall && (aw_stall_q != '1)) aw_stall_q <= aw_stall_q + 32'd1;
            if (ar_stall && (ar_stall_q != '1)) ar_stall_q <= ar_stall_q + 32'd1;
        end
    end

    assign o_aw_stall_cycles = aw_stall_q;
    assign o_ar_stall_cycles = ar_stall_q;
`else
    // Stall statistics are not built in this configuration.
`endif

endmodule

// File: tb/tb_multisim_server_axi_pull_ctrl.sv
// Directed self-checking bench: table-driven write path plus hand sequences.
module tb_multisim_server_axi_pull_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] s_aw;  logic s_awvalid; logic s_awready;
    logic [31:0] s_w;   logic s_wvalid;  logic s_wready;
    logic [15:0] s_ar;  logic s_arvalid; logic s_arready;
    logic [1:0]  s_b;   logic s_bvalid;  logic s_bready;
    logic [39:0] s_r;   logic s_rvalid;  logic s_rready;
    logic [15:0] m_aw;  logic m_awvalid; logic m_awready;
    logic [31:0] m_w;   logic m_wvalid;  logic m_wready;
    logic [15:0] m_ar;  logic m_arvalid; logic m_arready;
    logic [1:0]  m_b;   logic m_bvalid;  logic m_bready;
    logic [39:0] m_r;   logic m_rvalid;  logic m_rready;
    logic        m_rlast;
    logic [1:0]  wr_out;
    logic        rd_out;
    logic        idle, err;
`ifdef MULTISIM_SERVER_AXI_PULL_CTRL_STATS_EN
    logic [31:0] aw_stall, ar_stall;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multisim_server_axi_pull_ctrl #(
        .axi_aw_t(logic [15:0]), .axi_w_t(logic [31:0]), .axi_b_t(logic [1:0]),
        .axi_ar_t(logic [15:0]), .axi_r_t(logic [39:0]),
        .FIFO_DEPTH(4), .MAX_WR_OUTSTANDING(2), .MAX_RD_OUTSTANDING(1)
    ) dut (
        .clk(clk), .rst(rst),
        .s_aw(s_aw), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_w(s_w), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_ar(s_ar), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_b(s_b), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_r(s_r), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .o_axi_m_aw(m_aw), .o_axi_m_awvalid(m_awvalid), .i_axi_m_awready(m_awready),
        .o_axi_m_w(m_w), .o_axi_m_wvalid(m_wvalid), .i_axi_m_wready(m_wready),
        .o_axi_m_ar(m_ar), .o_axi_m_arvalid(m_arvalid), .i_axi_m_arready(m_arready),
        .i_axi_m_b(m_b), .i_axi_m_bvalid(m_bvalid), .o_axi_m_bready(m_bready),
        .i_axi_m_r(m_r), .i_axi_m_rvalid(m_rvalid), .o_axi_m_rready(m_rready),
        .i_axi_m_rlast(m_rlast),
        .o_wr_outstanding(wr_out), .o_rd_outstanding(rd_out),
        .o_idle(idle), .o_err(err)
`ifdef MULTISIM_SERVER_AXI_PULL_CTRL_STATS_EN
       ,.o_aw_stall_cycles(aw_stall), .o_ar_stall_cycles(ar_stall)
`endif
    );

    typedef struct {
        logic        aw_v;
        logic [15:0] aw_d;
        logic        awready;
        logic        bvalid;
        logic        exp_awvalid;
        logic [15:0] exp_aw;
        logic [1:0]  exp_wr;
        logic        exp_idle;
        logic        exp_err;
    } vec_t;

    vec_t tbl [15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        s_aw = '0; s_awvalid = 0; s_w = '0; s_wvalid = 0; s_ar = '0; s_arvalid = 0;
        s_bready = 1; s_rready = 1;
        m_awready = 0; m_wready = 0; m_arready = 0;
        m_b = 2'b10; m_bvalid = 0; m_r = '0; m_rvalid = 0; m_rlast = 0;

        // aw_v, aw_d, awready, bvalid | awvalid, aw, wr_out, idle, err
        tbl[0]  = '{1'b1, 16'hA001, 1'b1, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 16'hA002, 1'b1, 1'b0, 1'b1, 16'hA001, 2'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 16'hA003, 1'b1, 1'b0, 1'b1, 16'hA002, 2'd1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 16'hA004, 1'b1, 1'b0, 1'b0, 16'h0000, 2'd2, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 2'd2, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'hA003, 2'd2, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 2'd2, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'hA004, 2'd2, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hA004, 2'd1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'hA004, 2'd1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 2'd2, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 2'd1, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b1, 1'b1};

        // Reset: outputs forced quiet even with upstream traffic presented.
        s_awvalid = 1; s_wvalid = 1; s_arvalid = 1; m_bvalid = 1; m_rvalid = 1;
        tick(); tick();
        check("rst_awvalid", m_awvalid, 0);
        check("rst_s_awready", s_awready, 0);
        check("rst_s_bvalid", s_bvalid, 0);
        check("rst_m_bready", m_bready, 0);
        check("rst_s_rvalid", s_rvalid, 0);
        check("rst_idle", idle, 1);
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0; m_bvalid = 0; m_rvalid = 0;
        rst = 1'b0;
        #1;
        check("post_rst_wr_out", wr_out, 0);
        check("post_rst_err", err, 0);

        // Table-driven AW issue / outstanding-limit / B sequence.
        for (int i = 0; i < 15; i++) begin
            s_awvalid = tbl[i].aw_v;
            s_aw      = tbl[i].aw_d;
            m_awready = tbl[i].awready;
            m_bvalid  = tbl[i].bvalid;
            #1;
            check($sformatf("tbl%0d_awvalid", i), m_awvalid, tbl[i].exp_awvalid);
            if (tbl[i].exp_awvalid)
                check($sformatf("tbl%0d_aw", i), m_aw, tbl[i].exp_aw);
            check($sformatf("tbl%0d_wr_out", i), wr_out, tbl[i].exp_wr);
            check($sformatf("tbl%0d_idle", i), idle, tbl[i].exp_idle);
            check($sformatf("tbl%0d_err", i), err, tbl[i].exp_err);
            check($sformatf("tbl%0d_s_bvalid", i), s_bvalid, tbl[i].bvalid);
            if (tbl[i].bvalid)
                check($sformatf("tbl%0d_s_b", i), s_b, 2'b10);
            tick();
        end
        s_awvalid = 0; m_bvalid = 0;

        // Reset mid-burst with two entries queued and o_err set.
        m_awready = 0;
        s_awvalid = 1; s_aw = 16'hB001; tick();
        s_aw = 16'hB002; tick();
        s_awvalid = 0;
        #1;
        check("mid_awvalid_before", m_awvalid, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_awvalid", m_awvalid, 0);
        check("mid_rst_idle", idle, 1);
        tick();
        rst = 1'b0;
        #1;
        check("mid_after_awvalid", m_awvalid, 0);
        check("mid_after_wr_out", wr_out, 0);
        check("mid_after_err", err, 0);
        check("mid_after_idle", idle, 1);

        // FIFO fill to depth 4 with awready low; fifth push refused.
        s_awvalid = 1;
        for (int i = 0; i < 5; i++) begin
            s_aw = 16'h0100 + 16'(i);
            #1;
            check($sformatf("fill%0d_s_awready", i), s_awready, (i < 4) ? 1'b1 : 1'b0);
            tick();
        end
        // s_aw still presents 0x0104; pop at full, then refill.
        m_awready = 1;
        #1;
        check("full_pop_aw", m_aw, 16'h0100);
        check("full_pop_s_awready", s_awready, 0);
        tick();
        m_awready = 0;
        #1;
        check("after_pop_s_awready", s_awready, 1);
        check("after_pop_head", m_aw, 16'h0101);
        tick();
        s_awvalid = 0;
        #1;
        check("refull_s_awready", s_awready, 0);
        // Drain with B returned every cycle so the limit never bites.
        m_awready = 1; m_bvalid = 1;
        for (int i = 1; i < 5; i++) begin
            #1;
            check($sformatf("drain%0d_awvalid", i), m_awvalid, 1);
            check($sformatf("drain%0d_aw", i), m_aw, 16'h0100 + 16'(i));
            check($sformatf("drain%0d_wr_out", i), wr_out, 1);
            tick();
        end
        tick();
        m_bvalid = 0;
        #1;
        check("drain_wr_out", wr_out, 0);
        check("drain_idle", idle, 1);
        check("drain_err", err, 0);

        // W path: not gated by the count, one-cycle latency, order kept.
        m_wready = 0;
        s_wvalid = 1; s_w = 32'hCAFE_00A0;
        #1;
        check("w0_wvalid_pre", m_wvalid, 0);
        tick();
        s_w = 32'hCAFE_00A1;
        #1;
        check("w0_wvalid", m_wvalid, 1);
        check("w0_data", m_w, 32'hCAFE_00A0);
        tick();
        s_wvalid = 0; m_wready = 1;
        #1;
        check("w_drain0", m_w, 32'hCAFE_00A0);
        tick();
        #1;
        check("w_drain1", m_w, 32'hCAFE_00A1);
        check("w_drain1_valid", m_wvalid, 1);
        tick();
        #1;
        check("w_empty_valid", m_wvalid, 0);
        m_wready = 0;

        // Read burst of 4 beats; count drops only on the rlast beat.
        s_arvalid = 1; s_ar = 16'h0055; m_arready = 1;
        tick();
        s_arvalid = 0;
        #1;
        check("ar_valid", m_arvalid, 1);
        check("ar_data", m_ar, 16'h0055);
        tick();
        for (int i = 0; i < 4; i++) begin
            m_rvalid = 1;
            m_r      = 40'h10_0000_0000 + 40'(i * 3 + 7);
            m_rlast  = (i == 3);
            #1;
            check($sformatf("r%0d_rd_out", i), rd_out, 1);
            check($sformatf("r%0d_s_r", i), s_r, 40'h10_0000_0000 + 40'(i * 3 + 7));
            check($sformatf("r%0d_s_rvalid", i), s_rvalid, 1);
            tick();
        end
        m_rvalid = 0; m_rlast = 0;
        #1;
        check("r_done_rd_out", rd_out, 0);
        check("r_done_err", err, 0);
        s_rready = 0; m_rvalid = 1;
        #1;
        check("r_bp_m_rready", m_rready, 0);
        m_rvalid = 0; s_rready = 1;

`ifdef MULTISIM_SERVER_AXI_PULL_CTRL_STATS_EN
        // Second AR blocked by MAX_RD_OUTSTANDING=1 for 10 cycles.
        do_reset();
        s_arvalid = 1; s_ar = 16'h00A1; m_arready = 1;
        tick();
        s_ar = 16'h00A2;
        #1;
        check("st_ar1", m_ar, 16'h00A1);
        tick();
        s_arvalid = 0;
        #1;
        check("st_blocked", m_arvalid, 0);
        check("st_rd_out", rd_out, 1);
        repeat (10) tick();
        check("st_ar_stall", ar_stall, 10);
        check("st_aw_stall", aw_stall, 0);
        m_rvalid = 1; m_rlast = 1;
        #1;
        check("st_release_valid", m_arvalid, 1);
        check("st_release_ar", m_ar, 16'h00A2);
        tick();
        m_rvalid = 0; m_rlast = 0;
        #1;
        check("st_release_rd_out", rd_out, 1);
        check("st_ar_stall_hold", ar_stall, 10);
`else
        do_reset();
        #1;
        check("final_idle", idle, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
